// File: rtl/mem_arbiter.sv
// mem_arbiter
// ----------------------------------------------------------------------------
// Memory responder for the cpu16 instruction and data ports. It shares one
// single-port synchronous SRAM between three CPU request types (instruction
// read, data read and data write) and the SPI debug write stream.
//
// Debug writes cannot be stalled, so they always take the memory port. CPU
// grants are only made in IDLE. Instruction and data classes alternate when
// both are waiting.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   ins_rd_addr/req/rdy/data   instruction read: level req, 1-cycle rdy pulse
//   dat_rw_addr                shared address for data read and data write
//   dat_rd_req/rdy/data        data read: level req, 1-cycle rdy pulse
//   dat_wr_req/data/rdy        data write: level req, 1-cycle rdy pulse
//   dbg_we/waddr/wdata         debug write strobe, accepted the same cycle
//   mem_addr/wdata/we/re       SRAM command (combinational)
//   mem_rdata                  SRAM read data, valid the cycle after mem_re
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ins_rd_addr,
  input  logic          ins_rd_req,
  output logic          ins_rd_rdy,
  output logic [DW-1:0] ins_rd_data,
  input  logic [AW-1:0] dat_rw_addr,
  input  logic          dat_rd_req,
  output logic          dat_rd_rdy,
  output logic [DW-1:0] dat_rd_data,
  input  logic          dat_wr_req,
  input  logic [DW-1:0] dat_wr_data,
  output logic          dat_wr_rdy,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_waddr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          prefer_ins_q, prefer_ins_d;  // 1: instruction wins a tie
  logic          win_dat_q, win_dat_d;        // owner of the read in flight
  logic          ins_rd_rdy_q, ins_rd_rdy_d;
  logic          dat_rd_rdy_q, dat_rd_rdy_d;
  logic          dat_wr_rdy_q, dat_wr_rdy_d;
  logic [DW-1:0] ins_rd_data_q, ins_rd_data_d;
  logic [DW-1:0] dat_rd_data_q, dat_rd_data_d;

  // A request whose rdy is high this cycle is the one just completed; the CPU
  // has not yet seen the pulse, so it must not be granted a second time.
  logic ins_elig, dat_rd_elig, dat_wr_elig, dat_elig;
  assign ins_elig    = ins_rd_req & ~ins_rd_rdy_q;
  assign dat_rd_elig = dat_rd_req & ~dat_rd_rdy_q;
  assign dat_wr_elig = dat_wr_req & ~dat_wr_rdy_q;
  assign dat_elig    = dat_rd_elig | dat_wr_elig;

  // Grant decode: debug write blocks every CPU grant, and so does RD_WAIT.
  logic grant_ins, grant_dat_rd, grant_dat_wr;
  always_comb begin
    grant_ins    = 1'b0;
    grant_dat_rd = 1'b0;
    grant_dat_wr = 1'b0;
    if (state_q == IDLE && !dbg_we) begin
      if (ins_elig && (!dat_elig || prefer_ins_q)) begin
        grant_ins = 1'b1;
      end else if (dat_wr_elig) begin
        grant_dat_wr = 1'b1;
      end else if (dat_rd_elig) begin
        grant_dat_rd = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      prefer_ins_q  <= 1'b1;
      win_dat_q     <= 1'b0;
      ins_rd_rdy_q  <= 1'b0;
      dat_rd_rdy_q  <= 1'b0;
      dat_wr_rdy_q  <= 1'b0;
      ins_rd_data_q <= '0;
      dat_rd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      prefer_ins_q  <= prefer_ins_d;
      win_dat_q     <= win_dat_d;
      ins_rd_rdy_q  <= ins_rd_rdy_d;
      dat_rd_rdy_q  <= dat_rd_rdy_d;
      dat_wr_rdy_q  <= dat_wr_rdy_d;
      ins_rd_data_q <= ins_rd_data_d;
      dat_rd_data_q <= dat_rd_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    prefer_ins_d  = prefer_ins_q;
    win_dat_d     = win_dat_q;
    ins_rd_data_d = ins_rd_data_q;
    dat_rd_data_d = dat_rd_data_q;
    dat_wr_rdy_d  = grant_dat_wr;
    ins_rd_rdy_d  = 1'b0;
    dat_rd_rdy_d  = 1'b0;

    if (state_q == IDLE) begin
      if (grant_ins || grant_dat_rd) begin
        state_d   = RD_WAIT;
        win_dat_d = grant_dat_rd;
      end
    end else begin
      // mem_rdata is valid now; capture it so data is stable when rdy rises.
      state_d = IDLE;
      if (win_dat_q) begin
        dat_rd_data_d = mem_rdata;
        dat_rd_rdy_d  = 1'b1;
      end else begin
        ins_rd_data_d = mem_rdata;
        ins_rd_rdy_d  = 1'b1;
      end
    end

    // The pointer remembers the class granted last so the other wins a tie.
    if (grant_ins) begin
      prefer_ins_d = 1'b0;
    end else if (grant_dat_rd || grant_dat_wr) begin
      prefer_ins_d = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (dbg_we) begin
        mem_we    = 1'b1;
        mem_addr  = dbg_waddr;
        mem_wdata = dbg_wdata;
      end else if (grant_dat_wr) begin
        mem_we    = 1'b1;
        mem_addr  = dat_rw_addr;
        mem_wdata = dat_wr_data;
      end else if (grant_ins) begin
        mem_re   = 1'b1;
        mem_addr = ins_rd_addr;
      end else if (grant_dat_rd) begin
        mem_re   = 1'b1;
        mem_addr = dat_rw_addr;
      end
    end
  end

  assign ins_rd_rdy  = ins_rd_rdy_q;
  assign dat_rd_rdy  = dat_rd_rdy_q;
  assign dat_wr_rdy  = dat_wr_rdy_q;
  assign ins_rd_data = ins_rd_data_q;
  assign dat_rd_data = dat_rd_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed scenarios plus a randomized run for mem_arbiter. A behavioural SRAM
// sits on the memory port; expected data comes from ref_mem, a plain array of
// what each address should hold given every write the bench has issued.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ins_rd_addr;
  logic          ins_rd_req;
  logic          ins_rd_rdy;
  logic [DW-1:0] ins_rd_data;
  logic [AW-1:0] dat_rw_addr;
  logic          dat_rd_req;
  logic          dat_rd_rdy;
  logic [DW-1:0] dat_rd_data;
  logic          dat_wr_req;
  logic [DW-1:0] dat_wr_data;
  logic          dat_wr_rdy;
  logic          dbg_we;
  logic [AW-1:0] dbg_waddr;
  logic [DW-1:0] dbg_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req),
    .ins_rd_rdy(ins_rd_rdy), .ins_rd_data(ins_rd_data),
    .dat_rw_addr(dat_rw_addr), .dat_rd_req(dat_rd_req),
    .dat_rd_rdy(dat_rd_rdy), .dat_rd_data(dat_rd_data),
    .dat_wr_req(dat_wr_req), .dat_wr_data(dat_wr_data), .dat_wr_rdy(dat_wr_rdy),
    .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  logic [DW-1:0] sram    [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] seed_val(input int unsigned a);
    logic [31:0] p;
    p = a * 32'd40503;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ins_rd_req = 1'b0; dat_rd_req = 1'b0; dat_wr_req = 1'b0; dbg_we = 1'b0;
    ins_rd_addr = '0; dat_rw_addr = '0; dat_wr_data = '0;
    dbg_waddr = '0; dbg_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ins_rd_req = 1'b1; dat_rd_req = 1'b1; dat_wr_req = 1'b1; dbg_we = 1'b1;
    ins_rd_addr = 16'h0011; dat_rw_addr = 16'h0022; dbg_waddr = 16'h8001;
    smp();
    checks++;
    if ({ins_rd_rdy, dat_rd_rdy, dat_wr_rdy} !== 3'b000) begin
      errors++; $display("FAIL reset_rdy: got %b expected 000", {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy});
    end
    checks++;
    if (ins_rd_data !== 16'h0 || dat_rd_data !== 16'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0000/0000", ins_rd_data, dat_rd_data);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
      errors++; $display("FAIL reset_mem_en: got we=%b re=%b expected 0/0", mem_we, mem_re);
    end
    tick();
    idle_inputs();
    reset = 1'b0;
    smp();
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++; $display("FAIL idle_mem: got we=%b re=%b addr=%h wdata=%h expected 0/0/0000/0000",
                         mem_we, mem_re, mem_addr, mem_wdata);
    end
    $display("txn reset done");
  endtask

  task automatic test_ins_read();
    int pulses = 0;
    tick();
    ins_rd_req = 1'b1; ins_rd_addr = 16'h0010;
    smp();
    checks++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
      errors++; $display("FAIL ins_grant: got re=%b we=%b addr=%h expected 1/0/0010", mem_re, mem_we, mem_addr);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 3) ins_rd_req = 1'b0;
      smp();
      if (ins_rd_rdy === 1'b1) begin
        pulses++;
        checks++;
        if (c != 2 || ins_rd_data !== 16'hBEEF) begin
          errors++; $display("FAIL ins_rdy: got cycle N+%0d data=%h expected N+2 data=beef", c, ins_rd_data);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL ins_pulses: got %0d expected 1", pulses);
    end
    $display("txn ins_rd addr=0010 data=%h", ins_rd_data);
  endtask

  task automatic test_data_write();
    tick();
    dat_wr_req = 1'b1; dat_rw_addr = 16'h0020; dat_wr_data = 16'h1234;
    smp();
    checks++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234 || dat_wr_rdy !== 1'b0) begin
      errors++; $display("FAIL dwr_grant: got we=%b re=%b addr=%h wdata=%h rdy=%b expected 1/0/0020/1234/0",
                         mem_we, mem_re, mem_addr, mem_wdata, dat_wr_rdy);
    end
    ref_mem[16'h0020] = 16'h1234;
    tick();
    smp();
    checks++;
    if (dat_wr_rdy !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL dwr_rdy: got rdy=%b we=%b expected 1/0", dat_wr_rdy, mem_we);
    end
    $display("txn dat_wr addr=0020 data=1234");
    tick();
    dat_wr_req = 1'b0; dat_rd_req = 1'b1;
    smp();
    checks++;
    if (dat_wr_rdy !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 16'h0020) begin
      errors++; $display("FAIL drd_grant: got wrdy=%b re=%b addr=%h expected 0/1/0020", dat_wr_rdy, mem_re, mem_addr);
    end
    tick();
    smp();
    tick();
    smp();
    checks++;
    if (dat_rd_rdy !== 1'b1 || dat_rd_data !== 16'h1234) begin
      errors++; $display("FAIL drd_data: got rdy=%b data=%h expected 1/1234", dat_rd_rdy, dat_rd_data);
    end
    $display("txn dat_rd addr=0020 data=%h", dat_rd_data);
    tick();
    dat_rd_req = 1'b0;
  endtask

  task automatic test_debug_preempt();
    tick();
    dbg_we = 1'b1; dbg_waddr = 16'h8005; dbg_wdata = 16'h0041;
    dat_wr_req = 1'b1; dat_rw_addr = 16'h0030; dat_wr_data = 16'h5678;
    ref_mem[16'h8005] = 16'h0041;
    smp();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h8005 || mem_wdata !== 16'h0041 || dat_wr_rdy !== 1'b0) begin
      errors++; $display("FAIL dbg_first: got we=%b addr=%h wdata=%h rdy=%b expected 1/8005/0041/0",
                         mem_we, mem_addr, mem_wdata, dat_wr_rdy);
    end
    tick();
    dbg_we = 1'b0;
    smp();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0030 || mem_wdata !== 16'h5678 || dat_wr_rdy !== 1'b0) begin
      errors++; $display("FAIL cpu_second: got we=%b addr=%h wdata=%h rdy=%b expected 1/0030/5678/0",
                         mem_we, mem_addr, mem_wdata, dat_wr_rdy);
    end
    ref_mem[16'h0030] = 16'h5678;
    tick();
    smp();
    checks++;
    if (dat_wr_rdy !== 1'b1) begin
      errors++; $display("FAIL preempt_rdy: got %b expected 1", dat_wr_rdy);
    end
    tick();
    dat_wr_req = 1'b0;
    smp();
    checks++;
    if (sram[16'h8005] !== 16'h0041 || sram[16'h0030] !== 16'h5678) begin
      errors++; $display("FAIL preempt_mem: got %h/%h expected 0041/5678", sram[16'h8005], sram[16'h0030]);
    end
    $display("txn dbg_wr 8005=0041 then dat_wr 0030=5678");
  endtask

  task automatic test_fairness();
    int n_ins = 0, n_dat = 0, n_grants = 0, alt_err = 0;
    int last_cls = -1, g_ins = 0, g_dat = 0;
    int cyc = 0;
    tick();
    ins_rd_req = 1'b1; ins_rd_addr = 16'h0040;
    dat_rd_req = 1'b1; dat_rw_addr = 16'h0140;
    while ((n_ins < 4 || n_dat < 4) && cyc < 60) begin
      smp();
      if (mem_re === 1'b1) begin
        int cls;
        cls = (mem_addr == 16'h0040) ? 0 : 1;
        if (n_grants == 0 && cls != 0) alt_err++;
        if (cls == last_cls) alt_err++;
        last_cls = cls;
        n_grants++;
        if (cls == 0) g_ins = cyc; else g_dat = cyc;
      end
      if (ins_rd_rdy === 1'b1) begin
        n_ins++;
        checks++;
        if (ins_rd_data !== ref_mem[16'h0040] || cyc - g_ins != 2) begin
          errors++; $display("FAIL fair_ins: got data=%h lat=%0d expected %h lat=2", ins_rd_data, cyc - g_ins, ref_mem[16'h0040]);
        end
        $display("txn fair ins_rd #%0d data=%h", n_ins, ins_rd_data);
      end
      if (dat_rd_rdy === 1'b1) begin
        n_dat++;
        checks++;
        if (dat_rd_data !== ref_mem[16'h0140] || cyc - g_dat != 2) begin
          errors++; $display("FAIL fair_dat: got data=%h lat=%0d expected %h lat=2", dat_rd_data, cyc - g_dat, ref_mem[16'h0140]);
        end
        $display("txn fair dat_rd #%0d data=%h", n_dat, dat_rd_data);
      end
      tick();
      cyc++;
      ins_rd_req = (n_ins < 4);
      dat_rd_req = (n_dat < 4);
    end
    idle_inputs();
    checks++;
    if (n_ins != 4 || n_dat != 4 || n_grants != 8 || alt_err != 0) begin
      errors++; $display("FAIL fairness: got ins=%0d dat=%0d grants=%0d order_errs=%0d expected 4/4/8/0",
                         n_ins, n_dat, n_grants, alt_err);
    end
  endtask

  task automatic test_debug_rd_wait();
    tick();
    ins_rd_req = 1'b1; ins_rd_addr = 16'h0050;
    smp();
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 16'h0050) begin
      errors++; $display("FAIL rdw_grant: got re=%b addr=%h expected 1/0050", mem_re, mem_addr);
    end
    tick();
    dbg_we = 1'b1; dbg_waddr = 16'h9000; dbg_wdata = 16'hC3A5;
    ref_mem[16'h9000] = 16'hC3A5;
    smp();
    checks++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 16'h9000 || mem_wdata !== 16'hC3A5 || ins_rd_rdy !== 1'b0) begin
      errors++; $display("FAIL rdw_dbg: got we=%b re=%b addr=%h wdata=%h rdy=%b expected 1/0/9000/c3a5/0",
                         mem_we, mem_re, mem_addr, mem_wdata, ins_rd_rdy);
    end
    tick();
    dbg_we = 1'b0;
    smp();
    checks++;
    if (ins_rd_rdy !== 1'b1 || ins_rd_data !== ref_mem[16'h0050]) begin
      errors++; $display("FAIL rdw_read: got rdy=%b data=%h expected 1/%h", ins_rd_rdy, ins_rd_data, ref_mem[16'h0050]);
    end
    tick();
    ins_rd_req = 1'b0;
    smp();
    checks++;
    if (sram[16'h9000] !== 16'hC3A5) begin
      errors++; $display("FAIL rdw_mem: got %h expected c3a5", sram[16'h9000]);
    end
    $display("txn dbg_wr 9000=c3a5 during ins_rd 0050 data=%h", ins_rd_data);
  endtask

  task automatic test_reset_mid_read();
    int stray = 0;
    tick();
    dat_rd_req = 1'b1; dat_rw_addr = 16'h0060;
    smp();
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 16'h0060) begin
      errors++; $display("FAIL rst_rd_grant: got re=%b addr=%h expected 1/0060", mem_re, mem_addr);
    end
    tick();
    #1;
    reset = 1'b1;
    dat_rd_req = 1'b0;
    smp();
    checks++;
    if ({ins_rd_rdy, dat_rd_rdy, dat_wr_rdy} !== 3'b000 || ins_rd_data !== 16'h0 || dat_rd_data !== 16'h0
        || mem_re !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got rdy=%b data=%h/%h re=%b we=%b expected 000/0000/0000/0/0",
                         {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy}, ins_rd_data, dat_rd_data, mem_re, mem_we);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      smp();
      if (ins_rd_rdy || dat_rd_rdy || dat_wr_rdy || mem_re) stray++;
      tick();
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL rst_stray: got %0d stray events expected 0", stray);
    end
    ins_rd_req = 1'b1; ins_rd_addr = 16'h0070;
    smp();
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 16'h0070) begin
      errors++; $display("FAIL rst_idle: got re=%b addr=%h expected 1/0070", mem_re, mem_addr);
    end
    tick();
    tick();
    smp();
    checks++;
    if (ins_rd_rdy !== 1'b1 || ins_rd_data !== ref_mem[16'h0070]) begin
      errors++; $display("FAIL rst_after: got rdy=%b data=%h expected 1/%h", ins_rd_rdy, ins_rd_data, ref_mem[16'h0070]);
    end
    $display("txn reset mid-read, then ins_rd 0070 data=%h", ins_rd_data);
    tick();
    ins_rd_req = 1'b0;
  endtask

  task automatic test_random();
    logic          ins_act = 1'b0, dat_act = 1'b0, dat_is_wr = 1'b0;
    logic [15:0]   ins_a = '0, dat_a = '0, dat_d = '0;
    int            ins_wait = 0, dat_wait = 0, n_ins = 0, n_dat = 0, both = 0, bad_dbg = 0;
    for (int cyc = 0; cyc < 440; cyc++) begin
      tick();
      if (!ins_act && cyc < 400 && $urandom_range(0, 2) == 0) begin
        ins_act = 1'b1; ins_a = 16'($urandom_range(0, 255)); ins_wait = 0;
      end
      ins_rd_req = ins_act; ins_rd_addr = ins_a;
      if (!dat_act && cyc < 400 && $urandom_range(0, 2) == 0) begin
        dat_act = 1'b1; dat_is_wr = 1'($urandom_range(0, 1));
        dat_a = 16'h0100 | 16'($urandom_range(0, 255)); dat_d = 16'($urandom); dat_wait = 0;
      end
      dat_rd_req = dat_act & ~dat_is_wr; dat_wr_req = dat_act & dat_is_wr;
      dat_rw_addr = dat_a; dat_wr_data = dat_d;
      dbg_we = ($urandom_range(0, 3) == 0);
      dbg_waddr = 16'h8000 | 16'($urandom_range(0, 255)); dbg_wdata = 16'($urandom);
      if (dbg_we) ref_mem[dbg_waddr] = dbg_wdata;
      smp();
      if (mem_we && mem_re) both++;
      if (dbg_we && (mem_we !== 1'b1 || mem_addr !== dbg_waddr || mem_wdata !== dbg_wdata)) bad_dbg++;
      if (ins_rd_rdy) begin
        checks++;
        if (!ins_act || ins_rd_data !== ref_mem[ins_a]) begin
          errors++; $display("FAIL rnd_ins: got act=%b data=%h expected 1/%h addr=%h", ins_act, ins_rd_data, ref_mem[ins_a], ins_a);
        end
        $display("txn rnd ins_rd addr=%h data=%h", ins_a, ins_rd_data);
        ins_act = 1'b0; n_ins++;
      end else if (ins_act && ++ins_wait > 40) begin
        checks++; errors++;
        $display("FAIL rnd_ins_timeout: got no rdy in %0d cycles expected rdy", ins_wait);
        ins_act = 1'b0;
      end
      if (dat_rd_rdy || dat_wr_rdy) begin
        checks++;
        if (!dat_act || dat_rd_rdy !== ~dat_is_wr || dat_wr_rdy !== dat_is_wr
            || (dat_rd_rdy && dat_rd_data !== ref_mem[dat_a])) begin
          errors++; $display("FAIL rnd_dat: got act=%b rrdy=%b wrdy=%b data=%h expected wr=%b data=%h",
                             dat_act, dat_rd_rdy, dat_wr_rdy, dat_rd_data, dat_is_wr, ref_mem[dat_a]);
        end
        if (dat_wr_rdy) ref_mem[dat_a] = dat_d;
        $display("txn rnd dat_%s addr=%h data=%h", dat_is_wr ? "wr" : "rd", dat_a, dat_is_wr ? dat_d : dat_rd_data);
        dat_act = 1'b0; n_dat++;
      end else if (dat_act && ++dat_wait > 40) begin
        checks++; errors++;
        $display("FAIL rnd_dat_timeout: got no rdy in %0d cycles expected rdy", dat_wait);
        dat_act = 1'b0;
      end
    end
    tick();
    idle_inputs();
    smp();
    checks++;
    if (both != 0 || bad_dbg != 0 || n_ins == 0 || n_dat == 0 || ins_act || dat_act) begin
      errors++; $display("FAIL rnd_summary: got both=%0d bad_dbg=%0d ins=%0d dat=%0d pending=%b%b expected 0/0/>0/>0/00",
                         both, bad_dbg, n_ins, n_dat, ins_act, dat_act);
    end
    for (int a = 32'h8000; a < 32'h8100; a++) begin
      checks++;
      if (sram[16'(a)] !== ref_mem[16'(a)]) begin
        errors++; $display("FAIL rnd_dbg_mem: got %h expected %h at %h", sram[16'(a)], ref_mem[16'(a)], a);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = seed_val(i);
      ref_mem[i] = seed_val(i);
    end
    sram[16'h0010]    = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    test_reset();
    test_ins_read();
    test_data_write();
    test_debug_preempt();
    test_fairness();
    test_debug_rd_wait();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory responder for the cpu16 instruction and data request ports, replacing the fake always-ready handshake at top level.
- Arbitrates the CPU instruction-read, data-read and data-write requests, plus the SPI debug write stream, onto one single-port synchronous SRAM interface.
- Returns real read data with ready pulses.
- Debug writes always win because the debug interface cannot stall.

Parameters:
AW, 16, address width of all request ports and the memory port
DW, 16, data width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
ins_rd_addr  in  AW  instruction read address
ins_rd_req  in  1  instruction read request, level, held until ins_rd_rdy
ins_rd_rdy  out  1  one-cycle completion pulse for instruction read
ins_rd_data  out  DW  registered instruction read data
dat_rw_addr  in  AW  data read/write address
dat_rd_req  in  1  data read request, level
dat_rd_rdy  out  1  one-cycle completion pulse for data read
dat_rd_data  out  DW  registered data read data
dat_wr_req  in  1  data write request, level
dat_wr_data  in  DW  data write value
dat_wr_rdy  out  1  one-cycle completion pulse for data write
dbg_we  in  1  debug write strobe, single cycle, never stalled
dbg_waddr  in  AW  debug write address
dbg_wdata  in  DW  debug write data
mem_addr  out  AW  memory address (combinational mux)
mem_wdata  out  DW  memory write data
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable; mem_rdata is valid the following cycle
mem_rdata  in  DW  memory read data

Behaviour:
- Reset (async, active-high):
  - all rdy outputs 0; ins_rd_data and dat_rd_data 0.
  - FSM in IDLE; round-robin pointer favours instruction.
  - mem_we and mem_re are 0 while reset is high.
- FSM states: IDLE and RD_WAIT.
- Eligibility:
  - A CPU port is eligible when its req is high and its own rdy is not high this cycle.
  - This masking prevents a double grant while the CPU samples rdy.
- IDLE, highest priority first:
  1. dbg_we=1: mem_we=1, address and data taken from dbg_*. No CPU grant this cycle; pending CPU requests wait.
  2. Otherwise, if the instruction class and the data class are both eligible, grant the class not granted last. The pointer flips after each CPU grant.
  3. Within the data class, dat_wr beats dat_rd.
- Data write grant in cycle N:
  - mem_we=1, mem_addr=dat_rw_addr, mem_wdata=dat_wr_data.
  - dat_wr_rdy=1 in cycle N+1.
  - FSM stays in IDLE, so back-to-back grants are allowed.
- Read grant in cycle N:
  - mem_re=1, mem_addr=selected address.
  - The winner (ins or dat) is latched; the FSM goes to RD_WAIT.
- RD_WAIT (cycle N+1):
  - mem_rdata is captured into the winner's data register at the end of N+1.
  - The winner's rdy=1 in cycle N+2, with data already stable.
  - Return to IDLE.
  - Read latency from grant to rdy is 2 cycles; rdy is always a single-cycle pulse.
- Data registers hold their value until the next read completion on that port.
- Debug write in RD_WAIT: allowed, because the memory port is free that cycle (mem_we=1). The read still completes normally.
- No CPU grant is ever made in RD_WAIT.
- mem_we and mem_re are never both 1 in the same cycle.
- When no grant and no debug write occur, mem_addr=0 and mem_wdata=0.
- A req still high in the cycle after its rdy pulse is treated as a new request.
- Reset during RD_WAIT: the read is abandoned, no rdy is issued, and the data register is cleared.
- Address and data are passed through at full width; no truncation inside the block.

Test Plan:
- Single ins read: memory preloaded [0x0010]=0xBEEF; ins_rd_req=1, addr=0x0010 → mem_re cycle N, ins_rd_rdy pulse at N+2, ins_rd_data=0xBEEF, exactly one pulse.
- Data write: dat_wr_req=1, addr=0x0020, data=0x1234 → mem_we for one cycle with those values, dat_wr_rdy next cycle; a following dat_rd of 0x0020 returns 0x1234.
- Debug preemption: dbg_we=1 (0x8005, 0x0041) in the same cycle as dat_wr_req → debug write issued first, CPU write the next cycle, dat_wr_rdy one cycle later; no debug write lost.
- Fairness: ins_rd_req and dat_rd_req held high for 8 transactions → grants alternate ins/dat/ins/dat; 4 rdy pulses each; no starvation.
- Debug during RD_WAIT: ins read granted, dbg_we asserted in the following cycle → both the debug write and the read data are correct; ins_rd_rdy still lands at N+2.
- Reset mid-read: reset asserted during RD_WAIT → all rdy outputs 0, data registers 0, FSM IDLE; no rdy after release until a new request is made.
